execute: RTL and testbench
==========================

Name: execute

Overview:
- LC-3 pipeline execute stage, directly downstream of decode.
- Consumes the IR, npc, E_Control and W_Control values that decode registers.
- Performs ALU operations (ADD/AND/NOT) and PC-relative or base-relative address generation.
- Registers results for the writeback and memory stages. It also provides register-file source addresses combinationally to the register file.

Parameters:
- none (LC-3 widths are fixed: 16-bit data, 3-bit register addresses).

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- enable_execute  input  1  capture enable from the pipeline controller
- IR  input  16  instruction from decode
- npc_in  input  16  PC+1 from decode
- E_Control  input  6  [5:4] alu_control, [3:2] pcselect1, [1] pcselect2, [0] op2select
- W_Control_in  input  2  writeback select from decode (00 ALU, 01 memory, 10 pcout)
- VSR1  input  16  register file read data for sr1
- VSR2  input  16  register file read data for sr2
- sr1  output  3  combinational register source 1 address
- sr2  output  3  combinational register source 2 address
- aluout  output  16  registered ALU result or effective address
- pcout  output  16  registered address-adder result
- W_Control_out  output  2  registered copy of W_Control_in
- dr  output  3  registered destination register
- NZP  output  3  registered branch condition mask
- IR_Exec  output  16  registered copy of IR

Behaviour:
- Reset (rst=1 at posedge): aluout, pcout, IR_Exec = 0; W_Control_out, dr, NZP = 0. Reset overrides enable_execute.
- Latency: one cycle. Inputs sampled at posedge with enable_execute=1 appear on the outputs after that edge.
- enable_execute=0: aluout, pcout, W_Control_out, dr and IR_Exec hold. NZP clears to 000 so a branch fires for exactly one cycle.
- sr1 (combinational from IR): IR[8:6].
- sr2 (combinational from IR):
  - IR[11:9] for ST/STR/STI (opcodes 0011, 0111, 1011).
  - IR[2:0] otherwise.
- Sign extensions:
  - imm5 = sext(IR[4:0]).
  - offset6 = sext(IR[5:0]).
  - offset9 = sext(IR[8:0]).
  - offset11 = sext(IR[10:0]).
- ALU operand 2: VSR2 when op2select=1, imm5 when op2select=0.
- ALU result by alu_control:
  - 00: VSR1 + op2, modulo 2^16, carry discarded.
  - 01: VSR1 & op2.
  - 10: ~VSR1.
  - 11 (reserved): VSR1.
- Address adder: pcout = base + offset, modulo 2^16, wrap-around silent.
  - base = npc_in when pcselect2=1, VSR1 when pcselect2=0.
  - offset by pcselect1: 00 offset11, 01 offset9, 10 offset6, 11 zero.
- aluout:
  - ALU result for opcodes 0001, 0101, 1001.
  - pcout value for all other opcodes (memory effective address, LEA result).
- dr:
  - IR[11:9] for ADD, AND, NOT, LD, LDR, LDI, LEA (0001, 0101, 1001, 0010, 0110, 1010, 1110).
  - 000 otherwise.
- NZP:
  - IR[11:9] for BR (0000).
  - 111 for JMP (1100).
  - 000 for all other opcodes.
- W_Control_out and IR_Exec: straight registered copies of W_Control_in and IR.
- Unknown or unused opcodes: outputs still update per the rules above; no error flag.

Test Plan:
- Reset: rst=1 for 2 cycles with enable_execute=1 and random inputs -> all registered outputs read 0.
- ADD register form: IR=16'h1283 (R1=R2+R3), E_Control=6'b000001, VSR1=16'h0005, VSR2=16'hFFFE, enable_execute=1 -> after one edge aluout=16'h0003, dr=3'd1; combinationally sr1=3'd2, sr2=3'd3.
- AND immediate and NOT:
  - IR=16'h5270 (R1=R1 & -16), E_Control=6'b010000, VSR1=16'h1234 -> aluout=16'h1230.
  - IR=16'h927F (NOT), E_Control=6'b100000, VSR1=16'h00FF -> aluout=16'hFF00, dr=1.
- LEA with wrap: IR=16'hE1FF (R0, offset9=-1), E_Control=6'b000110, npc_in=16'h0000 -> pcout=16'hFFFF, aluout=16'hFFFF, dr=0, W_Control_out follows W_Control_in=2'b10.
- Branch one-shot: IR=16'h0E05 (BRnzp +5), E_Control=6'b000110, npc_in=16'h3001, enable high for 1 cycle then low -> NZP=111 and pcout=16'h3006 for one cycle, then NZP=000 while pcout holds 16'h3006.
- Store/JMP and hold:
  - IR=16'h7442 (STR R2,R1,#2) -> sr2=3'd2, sr1=3'd1, dr=0.
  - IR=16'hC1C0 (JMP R7), E_Control=6'b001100, VSR1=16'h4000 -> pcout=16'h4000, NZP=111.
  - Then with enable low and inputs changed, outputs hold.

Source files
------------

// File: rtl/execute.sv
// LC-3 execute stage: ALU (ADD/AND/NOT) and address generation.
// Results are registered for the writeback and memory stages.
module execute (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable_execute,
    input  logic [15:0] IR,
    input  logic [15:0] npc_in,
    input  logic [5:0]  E_Control,
    input  logic [1:0]  W_Control_in,
    input  logic [15:0] VSR1,
    input  logic [15:0] VSR2,
    output logic [2:0]  sr1,
    output logic [2:0]  sr2,
    output logic [15:0] aluout,
    output logic [15:0] pcout,
    output logic [1:0]  W_Control_out,
    output logic [2:0]  dr,
    output logic [2:0]  NZP,
    output logic [15:0] IR_Exec
);
    logic [3:0]  w_opcode;
    logic [1:0]  w_alu_control;
    logic [1:0]  w_pcselect1;
    logic        w_pcselect2;
    logic        w_op2select;
    logic [15:0] w_imm5, w_off6, w_off9, w_off11;
    logic [15:0] w_op2, w_alu_res, w_base, w_offset, w_ea;
    logic [2:0]  w_dr, w_nzp;
    logic        w_is_alu;

    logic [15:0] r_aluout, r_pcout, r_ir_exec;
    logic [1:0]  r_wctl;
    logic [2:0]  r_dr, r_nzp;

    assign w_opcode      = IR[15:12];
    assign w_alu_control = E_Control[5:4];
    assign w_pcselect1   = E_Control[3:2];
    assign w_pcselect2   = E_Control[1];
    assign w_op2select   = E_Control[0];

    assign w_imm5  = {{11{IR[4]}}, IR[4:0]};
    assign w_off6  = {{10{IR[5]}}, IR[5:0]};
    assign w_off9  = {{7{IR[8]}},  IR[8:0]};
    assign w_off11 = {{5{IR[10]}}, IR[10:0]};

    // Stores read the data register through the sr2 port.
    assign sr1 = IR[8:6];
    assign sr2 = (w_opcode == 4'b0011 || w_opcode == 4'b0111 || w_opcode == 4'b1011)
                 ? IR[11:9] : IR[2:0];

    assign w_op2 = w_op2select ? VSR2 : w_imm5;

    always_comb begin
        w_alu_res = VSR1;
        case (w_alu_control)
            2'b00:   w_alu_res = VSR1 + w_op2;
            2'b01:   w_alu_res = VSR1 & w_op2;
            2'b10:   w_alu_res = ~VSR1;
            default: w_alu_res = VSR1;
        endcase
    end

    always_comb begin
        w_offset = 16'h0000;
        case (w_pcselect1)
            2'b00:   w_offset = w_off11;
            2'b01:   w_offset = w_off9;
            2'b10:   w_offset = w_off6;
            default: w_offset = 16'h0000;
        endcase
    end

    assign w_base = w_pcselect2 ? npc_in : VSR1;
    assign w_ea   = w_base + w_offset;

    assign w_is_alu = (w_opcode == 4'b0001) || (w_opcode == 4'b0101) || (w_opcode == 4'b1001);

    always_comb begin
        w_dr = 3'b000;
        case (w_opcode)
            4'b0001, 4'b0101, 4'b1001, 4'b0010,
            4'b0110, 4'b1010, 4'b1110: w_dr = IR[11:9];
            default:                   w_dr = 3'b000;
        endcase
    end

    always_comb begin
        w_nzp = 3'b000;
        case (w_opcode)
            4'b0000: w_nzp = IR[11:9];
            4'b1100: w_nzp = 3'b111;
            default: w_nzp = 3'b000;
        endcase
    end

    // NZP is a one-shot: it drops whenever the stage is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluout  <= 16'h0000;
            r_pcout   <= 16'h0000;
            r_ir_exec <= 16'h0000;
            r_wctl    <= 2'b00;
            r_dr      <= 3'b000;
            r_nzp     <= 3'b000;
        end else if (enable_execute) begin
            r_aluout  <= w_is_alu ? w_alu_res : w_ea;
            r_pcout   <= w_ea;
            r_ir_exec <= IR;
            r_wctl    <= W_Control_in;
            r_dr      <= w_dr;
            r_nzp     <= w_nzp;
        end else begin
            r_nzp     <= 3'b000;
        end
    end

    assign aluout        = r_aluout;
    assign pcout         = r_pcout;
    assign IR_Exec       = r_ir_exec;
    assign W_Control_out = r_wctl;
    assign dr            = r_dr;
    assign NZP           = r_nzp;
endmodule

// File: tb/tb_execute.sv
// Bench for the LC-3 execute stage: directed vector table plus randomized
// traffic checked against an arithmetic reference model.
module tb_execute;
    logic        clk = 1'b0;
    logic        rst, enable_execute;
    logic [15:0] IR, npc_in, VSR1, VSR2;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control_in;
    logic [2:0]  sr1, sr2, dr, NZP;
    logic [15:0] aluout, pcout, IR_Exec;
    logic [1:0]  W_Control_out;

    int n_pass = 0;
    int n_total = 0;

    // model state (registered outputs)
    int m_alu = 0, m_pc = 0, m_ir = 0, m_wc = 0, m_dr = 0, m_nzp = 0;

    always #5 clk = ~clk;

    execute dut (
        .clk(clk), .rst(rst), .enable_execute(enable_execute), .IR(IR),
        .npc_in(npc_in), .E_Control(E_Control), .W_Control_in(W_Control_in),
        .VSR1(VSR1), .VSR2(VSR2), .sr1(sr1), .sr2(sr2), .aluout(aluout),
        .pcout(pcout), .W_Control_out(W_Control_out), .dr(dr), .NZP(NZP),
        .IR_Exec(IR_Exec)
    );

    typedef struct {
        logic [15:0] ir, npc, vsr1, vsr2;
        logic [5:0]  ec;
        logic [1:0]  wc;
        logic        en;
        logic [15:0] e_alu, e_pc, e_ir;
        logic [2:0]  e_dr, e_nzp, e_sr1, e_sr2;
        logic [1:0]  e_wc;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic int sx(input int v, input int b);
        return (v >= (1 << (b - 1))) ? v - (1 << b) : v;
    endfunction

    function automatic int wrap16(input int v);
        return ((v % 65536) + 65536) % 65536;
    endfunction

    // Spec-level reference: updates the model registers for one clock edge.
    task automatic model_edge(input bit r, input bit en, input int ir, input int npc,
                              input int ec, input int wc, input int a, input int b);
        int opc, op2, alu, base, off, ea;
        if (r) begin
            m_alu = 0; m_pc = 0; m_ir = 0; m_wc = 0; m_dr = 0; m_nzp = 0;
            return;
        end
        if (!en) begin
            m_nzp = 0;
            return;
        end
        opc = ir >> 12;
        op2 = (ec & 1) ? b : sx(ir & 31, 5);
        case ((ec >> 4) & 3)
            0: alu = wrap16(a + op2);
            1: alu = a & wrap16(op2);
            2: alu = 65535 - a;
            default: alu = a;
        endcase
        base = ((ec >> 1) & 1) ? npc : a;
        case ((ec >> 2) & 3)
            0: off = sx(ir & 2047, 11);
            1: off = sx(ir & 511, 9);
            2: off = sx(ir & 63, 6);
            default: off = 0;
        endcase
        ea = wrap16(base + off);
        m_pc  = ea;
        m_alu = (opc == 1 || opc == 5 || opc == 9) ? alu : ea;
        m_ir  = ir;
        m_wc  = wc;
        m_dr  = (opc inside {1, 5, 9, 2, 6, 10, 14}) ? ((ir >> 9) & 7) : 0;
        m_nzp = (opc == 0) ? ((ir >> 9) & 7) : (opc == 12) ? 7 : 0;
    endtask

    function automatic int exp_sr2(input int ir);
        int opc;
        opc = ir >> 12;
        return (opc == 3 || opc == 7 || opc == 11) ? ((ir >> 9) & 7) : (ir & 7);
    endfunction

    task automatic drive(input bit r, input bit en, input logic [15:0] ir, input logic [15:0] npc,
                         input logic [5:0] ec, input logic [1:0] wc,
                         input logic [15:0] a, input logic [15:0] b);
        rst = r; enable_execute = en; IR = ir; npc_in = npc; E_Control = ec;
        W_Control_in = wc; VSR1 = a; VSR2 = b;
        @(posedge clk);
        model_edge(r, en, int'(ir), int'(npc), int'(ec), int'(wc), int'(a), int'(b));
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " aluout"}, int'(aluout), m_alu);
        chk({tag, " pcout"}, int'(pcout), m_pc);
        chk({tag, " IR_Exec"}, int'(IR_Exec), m_ir);
        chk({tag, " W_Control_out"}, int'(W_Control_out), m_wc);
        chk({tag, " dr"}, int'(dr), m_dr);
        chk({tag, " NZP"}, int'(NZP), m_nzp);
        chk({tag, " sr1"}, int'(sr1), (int'(IR) >> 6) & 7);
        chk({tag, " sr2"}, int'(sr2), exp_sr2(int'(IR)));
    endtask

    vec_t tbl[9];

    initial begin
        //          ir       npc      vsr1     vsr2     ec          wc     en    alu      pc       ir_exec  dr    nzp   sr1   sr2   wc_out
        tbl[0] = '{16'h1283, 16'h0000, 16'h0005, 16'hFFFE, 6'b000001, 2'b00, 1'b1, 16'h0003, 16'h0288, 16'h1283, 3'd1, 3'd0, 3'd2, 3'd3, 2'b00};
        tbl[1] = '{16'h5270, 16'h0000, 16'h1234, 16'h0000, 6'b010000, 2'b00, 1'b1, 16'h1230, 16'h14A4, 16'h5270, 3'd1, 3'd0, 3'd1, 3'd0, 2'b00};
        tbl[2] = '{16'h927F, 16'h0000, 16'h00FF, 16'h0000, 6'b100000, 2'b00, 1'b1, 16'hFF00, 16'h037E, 16'h927F, 3'd1, 3'd0, 3'd1, 3'd7, 2'b00};
        tbl[3] = '{16'hE1FF, 16'h0000, 16'h0000, 16'h0000, 6'b000110, 2'b10, 1'b1, 16'hFFFF, 16'hFFFF, 16'hE1FF, 3'd0, 3'd0, 3'd7, 3'd7, 2'b10};
        tbl[4] = '{16'h0E05, 16'h3001, 16'h0000, 16'h0000, 6'b000110, 2'b00, 1'b1, 16'h3006, 16'h3006, 16'h0E05, 3'd0, 3'd7, 3'd0, 3'd5, 2'b00};
        // stall after branch: NZP drops, everything else holds
        tbl[5] = '{16'h7442, 16'h1111, 16'h2222, 16'h3333, 6'b111111, 2'b11, 1'b0, 16'h3006, 16'h3006, 16'h0E05, 3'd0, 3'd0, 3'd1, 3'd2, 2'b00};
        tbl[6] = '{16'h7442, 16'h0000, 16'h1000, 16'h0000, 6'b001000, 2'b01, 1'b1, 16'h1002, 16'h1002, 16'h7442, 3'd0, 3'd0, 3'd1, 3'd2, 2'b01};
        tbl[7] = '{16'hC1C0, 16'h0000, 16'h4000, 16'h0000, 6'b001100, 2'b00, 1'b1, 16'h4000, 16'h4000, 16'hC1C0, 3'd0, 3'd7, 3'd7, 3'd0, 2'b00};
        tbl[8] = '{16'h1283, 16'h5555, 16'h0001, 16'h0002, 6'b000001, 2'b11, 1'b0, 16'h4000, 16'h4000, 16'hC1C0, 3'd0, 3'd0, 3'd2, 3'd3, 2'b00};

        rst = 1'b1; enable_execute = 1'b1; IR = '0; npc_in = '0; E_Control = '0;
        W_Control_in = '0; VSR1 = '0; VSR2 = '0;

        // reset with live inputs and enable high
        for (int i = 0; i < 2; i++)
            drive(1'b1, 1'b1, 16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom),
                  16'($urandom), 16'($urandom));
        chk("reset aluout", int'(aluout), 0);
        chk("reset pcout", int'(pcout), 0);
        chk("reset IR_Exec", int'(IR_Exec), 0);
        chk("reset W_Control_out", int'(W_Control_out), 0);
        chk("reset dr", int'(dr), 0);
        chk("reset NZP", int'(NZP), 0);

        for (int i = 0; i < 9; i++) begin
            drive(1'b0, tbl[i].en, tbl[i].ir, tbl[i].npc, tbl[i].ec, tbl[i].wc,
                  tbl[i].vsr1, tbl[i].vsr2);
            chk($sformatf("vec%0d aluout", i), int'(aluout), int'(tbl[i].e_alu));
            chk($sformatf("vec%0d pcout", i), int'(pcout), int'(tbl[i].e_pc));
            chk($sformatf("vec%0d IR_Exec", i), int'(IR_Exec), int'(tbl[i].e_ir));
            chk($sformatf("vec%0d dr", i), int'(dr), int'(tbl[i].e_dr));
            chk($sformatf("vec%0d NZP", i), int'(NZP), int'(tbl[i].e_nzp));
            chk($sformatf("vec%0d sr1", i), int'(sr1), int'(tbl[i].e_sr1));
            chk($sformatf("vec%0d sr2", i), int'(sr2), int'(tbl[i].e_sr2));
            chk($sformatf("vec%0d W_Control_out", i), int'(W_Control_out), int'(tbl[i].e_wc));
        end

        // branch one-shot then a second stall cycle: NZP stays low, pcout holds
        drive(1'b0, 1'b1, 16'h0E05, 16'h3001, 6'b000110, 2'b00, 16'h0, 16'h0);
        chk("br fire NZP", int'(NZP), 7);
        drive(1'b0, 1'b0, 16'h0E05, 16'h3001, 6'b000110, 2'b00, 16'h0, 16'h0);
        chk("br stall1 NZP", int'(NZP), 0);
        drive(1'b0, 1'b0, 16'h0E05, 16'h3001, 6'b000110, 2'b00, 16'h0, 16'h0);
        chk("br stall2 NZP", int'(NZP), 0);
        chk("br stall2 pcout", int'(pcout), 16'h3006);

        // reset wins over a stalled stage with held values
        drive(1'b1, 1'b0, 16'h1283, 16'h0, 6'b0, 2'b11, 16'h1, 16'h1);
        chk_model("rst-stall");

        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 29) == 0), ($urandom_range(0, 3) != 0),
                  16'($urandom), 16'($urandom), 6'($urandom), 2'($urandom),
                  16'($urandom), 16'($urandom));
            chk_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
